// File: rtl/pterm_config_loader.sv
// Serial loader for one product-term configuration word: bits are collected
// into a shadow register and committed to conf in a single edge.
module pterm_config_loader #(
  parameter int SIZE  = 6,
  parameter int CNT_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            bit_valid,
  input  logic            bit_in,
  output logic            bit_ready,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic            conf_valid,
  output logic [SIZE-1:0] conf,
  output logic [1:0]      fsm_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE - 1);

  // Handshake: a bit transfers on a rising edge where bit_valid and
  // bit_ready are both 1; bit_ready depends only on the state register.
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [SIZE-1:0]  shadow;

  assign bit_ready = (state == SHIFT);
  assign busy      = (state == SHIFT) || (state == COMMIT);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shadow     <= '0;
      conf       <= '0;
      conf_valid <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SHIFT;
            cnt    <= '0;
            shadow <= '0;
          end
        end
        SHIFT: begin
          // A restart takes priority; any bit offered in the same cycle is dropped.
          if (start) begin
            cnt    <= '0;
            shadow <= '0;
            error  <= 1'b1;
          end else if (bit_valid) begin
            shadow[cnt] <= bit_in;
            if (cnt == LAST) begin
              state <= COMMIT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        COMMIT: begin
          conf       <= shadow;
          conf_valid <= 1'b1;
          done       <= 1'b1;
          error      <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pterm_config_loader.sv
// Directed bench for pterm_config_loader: stimulus pushes expected committed
// words into a queue, a monitor pops and compares them on every done pulse.
module tb_pterm_config_loader;

  localparam int SIZE = 6;

  logic            clk = 1'b0;
  logic            clk_en = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            bit_valid = 1'b0;
  logic            bit_in = 1'b0;
  logic            bit_ready, busy, done, error, conf_valid;
  logic [SIZE-1:0] conf;
  logic [1:0]      fsm_state;

  logic [SIZE-1:0] exp_q[$];
  int              checks = 0;
  int              errors = 0;
  logic            done_prev = 1'b0;

  pterm_config_loader #(.SIZE(SIZE), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_ready(bit_ready), .busy(busy), .done(done), .error(error),
    .conf_valid(conf_valid), .conf(conf), .fsm_state(fsm_state)
  );

  // Clock / reset block: the clock can be held still to test async reset.
  always #5 if (clk_en) clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares every committed word against the queue head.
  always @(posedge clk) begin
    #1;
    if (done) begin
      checks++;
      if (done_prev) begin
        errors++;
        $display("FAIL done_width: done high on two consecutive edges");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: conf=%b with nothing expected", conf);
      end else begin
        logic [SIZE-1:0] e;
        e = exp_q.pop_front();
        if (conf !== e || conf_valid !== 1'b1 || error !== 1'b0) begin
          errors++;
          $display("FAIL commit: conf=%b conf_valid=%b error=%b expected conf=%b conf_valid=1 error=0",
                   conf, conf_valid, error, e);
        end
      end
    end
    done_prev = done;
  end

  // Driver: one full session. Bits go out in stream order (bits[0] first);
  // a gap of gap_len idle cycles is inserted after gap_at bits.
  task automatic load(input logic [SIZE-1:0] bits, input int gap_at, input int gap_len,
                      input bit commit_noise, input int exp_lat);
    int lat;
    exp_q.push_back(bits);
    start = 1'b1;
    tick();                      // E0
    start = 1'b0;
    lat = 0;
    for (int i = 0; i < SIZE; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          bit_valid = 1'b0;
          tick();
          lat++;
        end
      end
      bit_valid = 1'b1;
      bit_in    = bits[i];
      chk("bit_ready_shift", bit_ready, 1);
      tick();
      lat++;
    end
    chk("bit_ready_commit", {bit_ready, busy}, 2'b01);
    bit_valid = commit_noise;
    bit_in    = 1'b1;
    start     = commit_noise;
    tick();                      // commit edge
    lat++;
    bit_valid = 1'b0;
    start     = 1'b0;
    chk("commit_latency", lat, exp_lat);
    chk("done_pulse", done, 1);
    chk("idle_after_commit", {busy, fsm_state}, 3'b000);
    tick();
    chk("done_drop", done, 0);
    chk("conf_hold", conf, bits);
  endtask

  initial begin
    // Reset with the clock stopped.
    #1 rst = 1'b1;
    #2;
    chk("reset_outputs", {bit_ready, busy, done, error, conf_valid, conf}, 0);
    rst = 1'b0;
    bit_valid = 1'b1;
    clk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_outputs", {bit_ready, busy, done, error, conf_valid, conf}, 0);
    end
    bit_valid = 1'b0;

    // Full-rate load: stream 1,0,1,1,0,0 -> conf = 001101, commit at E7.
    load(6'b001101, SIZE, 0, 1'b0, SIZE + 1);
    chk("error_after_load", error, 0);

    // Gapped stream: 3 idle cycles after the second bit, commit at E10.
    load(6'b001101, 2, 3, 1'b0, SIZE + 4);

    // Restart in mid-session, with a bit offered on the restart edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      bit_in = 1'b1;
      tick();
    end
    start = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    tick();                      // restart edge
    start = 1'b0;
    chk("restart_error", error, 1);
    chk("restart_conf_kept", conf, 6'b001101);
    chk("restart_state", fsm_state, 1);
    begin
      logic [SIZE-1:0] rbits;
      rbits = 6'b110010;         // stream 0,1,0,0,1,1
      exp_q.push_back(rbits);
      for (int i = 0; i < SIZE; i++) begin
        bit_valid = 1'b1;
        bit_in = rbits[i];
        tick();
        chk("restart_error_held", error, 1);
        chk("restart_conf_held", conf, 6'b001101);
      end
      bit_valid = 1'b0;
      tick();                    // commit edge
      chk("restart_commit", {conf, error, done}, {rbits, 2'b01});
      tick();
    end

    // Reset in mid-session after a committed load.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      bit_in = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midreset_outputs", {conf_valid, conf, busy, fsm_state}, 0);
    rst = 1'b0;
    tick();
    load(6'b010110, SIZE, 0, 1'b0, SIZE + 1);

    // Ignored inputs: bit_valid in IDLE, bit_valid and start in COMMIT.
    bit_valid = 1'b1;
    bit_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_ignore", {busy, error, conf}, {2'b00, 6'b010110});
    end
    bit_valid = 1'b0;
    load(6'b100011, SIZE, 0, 1'b1, SIZE + 1);
    chk("commit_ignore_error", error, 0);
    load(6'b111111, SIZE, 0, 1'b0, SIZE + 1);

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pterm_config_loader.md
# pterm_config_loader

Serial configuration loader that sits directly upstream of the product-term AND array. It accepts the product-term bitstream one bit per handshake and assembles it in a shadow register. When exactly SIZE bits have been received, it commits the whole word atomically onto `conf`. The asynchronous AND array therefore never sees a partially loaded configuration.

## Interface
- `SIZE`, default 6: number of configuration bits per product term; `conf` width.
- `CNT_W`, default 3: width of the bit counter; must satisfy 2**CNT_W >= SIZE.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  begin (or restart) a load session.
- `bit_valid`  in  1  `bit_in` carries a stream bit.
- `bit_in`  in  1  serial configuration bit.
- `bit_ready`  out  1  loader accepts a bit this cycle.
- `busy`  out  1  session in progress (state != IDLE).
- `done`  out  1  one-cycle pulse: `conf` was just updated.
- `error`  out  1  sticky: the last session was aborted by a restart.
- `conf_valid`  out  1  `conf` holds a committed configuration.
- `conf`  out  SIZE  committed configuration to the AND array.

## Operation
- The FSM has three states: IDLE, SHIFT, COMMIT. A bit is accepted when `bit_valid` and `bit_ready` are both 1 at a rising edge.
- **IDLE**
  - `bit_ready` = 0; `bit_valid` is ignored.
  - `start` = 1 moves to SHIFT, sets `cnt` = 0 and clears `shadow` to 0.
- **SHIFT**
  - `bit_ready` = 1.
  - On accept: `shadow[cnt]` <= `bit_in`, then `cnt` increments.
  - Bit ordering: the first received bit maps to `conf[0]`, and stream index i maps to `conf[i]`. This is the same order in which the bitstream file is indexed.
  - The accept with `cnt` = SIZE-1 moves to COMMIT.
  - `start` = 1 in SHIFT means restart. It wins over a simultaneous accept, and that bit is discarded. On restart: `cnt` = 0, `shadow` = 0, `error` <= 1, and the FSM stays in SHIFT. `conf` is untouched.
- **COMMIT**
  - `bit_ready` = 0; `bit_valid` and `start` are ignored.
  - At the next edge: `conf` <= `shadow`, `conf_valid` <= 1, `done` <= 1, `error` <= 0, and the FSM returns to IDLE.
- `done` is registered and deasserts at the following edge unless another commit occurs (a commit cannot occur on consecutive edges).
- `busy` = 1 in SHIFT and COMMIT.
- `cnt` never exceeds SIZE-1; no wrap-around is possible.
- `conf` changes only at the COMMIT exit edge or on reset.

## Timing
- **Reset values** (applied asynchronously, no clock needed):
  - State IDLE, `cnt` = 0, `shadow` = 0.
  - `conf` = 0, `conf_valid` = 0, `done` = 0, `error` = 0.
  - `busy` = 0, `bit_ready` = 0.
- **Reset mid-session:** the session is lost and `conf` returns to 0, leaving the array unconfigured.
- **Latency at full rate:** with `start` sampled at edge E0, bits are accepted at E1..E(SIZE) and COMMIT is entered at E(SIZE). `conf`, `conf_valid` and `done` update at E(SIZE+1). For SIZE = 6, that is E7.
- **Stalls:** each cycle with `bit_valid` = 0 in SHIFT delays commit by one cycle. There is no timeout.
- **`start` in the `done` cycle:** a `start` in the IDLE cycle where `done` = 1 is legal. It opens a new session at the next edge.
- **Outputs:** `bit_ready` and `busy` are decoded from the state register. `conf`, `conf_valid`, `done` and `error` are flops.

## Test plan
- **Reset:** assert `rst` with the clock stopped.
  - Required: every output is 0 immediately.
  - Then release `rst`, toggle the clock 5 cycles with `bit_valid` = 1. Required: all outputs stay 0.
- **Full-rate load (SIZE = 6):** `start` at E0, then stream 1,0,1,1,0,0 on consecutive cycles.
  - Required: `bit_ready` = 1 during E1..E6 and 0 in COMMIT.
  - Required at E7: `conf` = 6'b001101, `conf_valid` = 1, `done` = 1 for exactly one cycle, `error` = 0.
- **Gapped stream:** same bits as the full-rate load, with `bit_valid` = 0 for 3 cycles between bits 2 and 3.
  - Required: `conf` = 6'b001101 at E10.
- **Restart:** after a successful load of 6'b001101, `start`, 3 bits, `start` again, then bits 0,1,0,0,1,1.
  - Required: `error` = 1 from the restart edge onward.
  - Required: `conf` holds 6'b001101 until commit, then becomes 6'b110010 with `error` = 0.
- **Reset mid-operation:** after a committed load, start a new session and accept 4 bits, then pulse `rst` asynchronously.
  - Required: `conf` = 0, `conf_valid` = 0, state IDLE.
  - Then run a full load. Required: it commits normally.
- **Ignored inputs:** `bit_valid` pulses in IDLE and in COMMIT, and `start` in COMMIT.
  - Required: no change to `cnt`, `conf` or `error`.
  - Required: a following load of 1,1,1,1,1,1 gives `conf` = 6'b111111.
